// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

    localparam logic [31:0] DEFAULT_PATTERN = 32'b1011;
    localparam int          DEFAULT_LEN     = 4;
    localparam logic        DEFAULT_OVERLAP = 1'b1;

    // A zero-length pattern would match nothing meaningful, so it is treated as length 1.
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw < 1)
            return 1;
        else if (raw > max_len)
            return max_len;
        else
            return raw;
    endfunction

endpackage

// File: rtl/seq_window.sv
// History shift register and fill counter with a length-masked compare against the pattern.
module seq_window
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               restart,
    input  logic               shift_en,
    input  logic               in_bit,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               hit
);

    // Only MAX_LEN-1 older bits need storing; the newest bit comes straight from in_bit.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic               armed_next;

    assign window = {hist, in_bit};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    assign armed_next = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);
    assign hit        = armed_next && ((window & mask) == (pattern & mask));

    always_ff @(posedge clk) begin
        if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[MAX_LEN-2:0];
            if (restart)
                fill <= '0;
            else if (fill < len)
                fill <= fill + LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: configuration registers, match pulse and saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               hit;
    logic               accept;

    assign accept = in_valid && !reset && !cfg_we;

    seq_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk      (clk),
        .clear    (reset || cfg_we),
        .restart  (hit && !overlap_q),
        .shift_en (accept),
        .in_bit   (in_bit),
        .len      (len_q),
        .pattern  (pattern_q),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= DEFAULT_PATTERN[MAX_LEN-1:0];
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= DEFAULT_OVERLAP;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            overlap_q <= cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cfg_we) begin
            seq_seen    <= 1'b0;
            match_count <= '0;
        end else if (in_valid) begin
            seq_seen <= hit;
            if (hit && (match_count != '1))
                match_count <= match_count + CNT_W'(1);
        end else begin
            seq_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench: directed scenarios plus random traffic against a stream-based reference model.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               seq_seen, seq_seen_sat;
    logic [7:0]         match_count;
    logic [1:0]         match_count_sat;

    int checks = 0;
    int errors = 0;

    // Reference model state: accepted bits since the last clear, and bits since the last restart.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    logic               m_ov;
    bit                 stream[$];
    int                 since;
    logic               exp_seen;
    int                 cnt, cnt_sat;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .seq_seen(seq_seen), .match_count(match_count)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .seq_seen(seq_seen_sat), .match_count(match_count_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        stream.delete();
        since    = 0;
        exp_seen = 1'b0;
        cnt      = 0;
        cnt_sat  = 0;
    endtask

    task automatic model_update(input logic r, input logic we, input logic v, input logic b);
        bit ok;
        if (r) begin
            m_pat = 8'b1011;
            m_len = 4;
            m_ov  = 1'b1;
            model_clear();
        end else if (we) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
            m_ov  = cfg_overlap;
            model_clear();
        end else if (v) begin
            stream.push_back(b);
            if (stream.size() > 40) void'(stream.pop_front());
            since++;
            ok = (since >= m_len);
            for (int k = 0; k < m_len && ok; k++)
                if (stream[stream.size() - 1 - k] != m_pat[k]) ok = 0;
            exp_seen = ok;
            if (ok) begin
                if (cnt < 255) cnt++;
                if (cnt_sat < 3) cnt_sat++;
                if (!m_ov) since = 0;
            end
        end else begin
            exp_seen = 1'b0;
        end
    endtask

    task automatic cycle(input logic r, input logic we, input logic v, input logic b);
        reset    = r;
        cfg_we   = we;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        model_update(r, we, v, b);
        #1;
        check("seq_seen", {31'd0, seq_seen}, {31'd0, exp_seen});
        check("match_count", {24'd0, match_count}, cnt);
        check("seq_seen_sat", {31'd0, seq_seen_sat}, {31'd0, exp_seen});
        check("match_count_sat", {30'd0, match_count_sat}, cnt_sat);
    endtask

    task automatic send(input logic b);
        cycle(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic gap();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ov);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic r, we, v, b;
        logic [7:0] long_pat;

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_count", {24'd0, match_count}, 0);

        // Reset configuration detects 1011.
        send(1); send(0); send(1); send(1);
        check("default_pulse", {31'd0, seq_seen}, 1);
        check("default_count", {24'd0, match_count}, 1);
        gap();

        load(8'b101, 4'd3, 1'b1);
        send(1); send(0); send(1); send(0); send(1);
        check("overlap_count", {24'd0, match_count}, 2);

        load(8'b101, 4'd3, 1'b0);
        send(1); send(0); send(1); send(0); send(1);
        check("nonoverlap_count", {24'd0, match_count}, 1);

        // Idle cycles between bits must not disturb the partial match.
        load(8'b1011, 4'd4, 1'b1);
        send(1); gap(); gap(); send(0); gap(); send(1); gap(); gap(); send(1);
        check("gap_pulse", {31'd0, seq_seen}, 1);
        gap();
        check("gap_count", {24'd0, match_count}, 1);

        load(8'b1, 4'd0, 1'b1);
        send(1); send(1); send(1);
        check("len0_count", {24'd0, match_count}, 3);

        long_pat = 8'b1011_0011;
        load(long_pat, 4'(MAX_LEN + 3), 1'b1);
        send(0); send(1);
        for (int i = MAX_LEN - 1; i >= 0; i--) send(long_pat[i]);
        check("lenmax_count", {24'd0, match_count}, 1);

        load(8'b1, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) send(1);
        check("sat_count", {30'd0, match_count_sat}, 3);
        check("unsat_count", {24'd0, match_count}, 5);

        // A config write mid-pattern discards the partial match.
        load(8'b1011, 4'd4, 1'b1);
        send(1); send(0); send(1);
        load(8'b1011, 4'd4, 1'b1);
        send(1);
        check("cfg_disrupt_nopulse", {31'd0, seq_seen}, 0);
        send(0); send(1); send(1);
        check("cfg_disrupt_refill", {31'd0, seq_seen}, 1);

        send(1); send(0); send(1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        send(1);
        check("rst_disrupt_nopulse", {31'd0, seq_seen}, 0);
        send(0); send(1); send(1);
        check("rst_disrupt_refill", {31'd0, seq_seen}, 1);

        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            we = ($urandom_range(0, 99) < 4);
            v  = ($urandom_range(0, 99) < 80);
            b  = 1'($urandom_range(0, 1));
            if (we) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 3));
                cfg_overlap = 1'($urandom_range(0, 1));
            end
            cycle(r, we, v, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
